// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory stage.
//   - Opcodes of the supported load/store instructions
//   - Reset value of the pipeline PC
//   - Access-size enum and a small opcode decoder that both the M-stage
//     top and its lane-extension helper use.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } sz_e;

    typedef struct packed {
        logic is_load;
        logic is_store;
        sz_e  size;
        logic sign_ext;
    } mem_op_t;

    // Classify an opcode; non-memory opcodes return both flags cleared.
    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, sign_ext: 1'b0};
        case (op)
            OP_LW:   d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_WORD, sign_ext: 1'b0};
            OP_LH:   d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_HALF, sign_ext: 1'b1};
            OP_LHU:  d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_HALF, sign_ext: 1'b0};
            OP_LB:   d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sign_ext: 1'b1};
            OP_LBU:  d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sign_ext: 1'b0};
            OP_SW:   d = '{is_load: 1'b0, is_store: 1'b1, size: SZ_WORD, sign_ext: 1'b0};
            OP_SH:   d = '{is_load: 1'b0, is_store: 1'b1, size: SZ_HALF, sign_ext: 1'b0};
            OP_SB:   d = '{is_load: 1'b0, is_store: 1'b1, size: SZ_BYTE, sign_ext: 1'b0};
            default: d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, sign_ext: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Combinational load-data formatter: selects the addressed half/byte lane of
// a memory word (little-endian, lane 0 = bits [7:0]) and sign- or
// zero-extends it to 32 bits.
// Ports:
//   word_i     32  raw memory word
//   lane_i      2  byte address bits [1:0]
//   size_i     sz  access size (word/half/byte)
//   sign_ext_i  1  1 = sign-extend, 0 = zero-extend
//   data_o     32  formatted load data
module dm_ext
    import mips_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  sz_e         size_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Pick the addressed lanes, then extend according to access size.
    always_comb begin
        half_s = 16'h0000;
        byte_s = 8'h00;
        data_o = 32'h0000_0000;
        if (lane_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
        case (lane_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        case (size_i)
            SZ_WORD: data_o = word_i;
            SZ_HALF: data_o = {{16{sign_ext_i & half_s[15]}}, half_s};
            SZ_BYTE: data_o = {{24{sign_ext_i & byte_s[7]}}, byte_s};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage_dm.sv
// M-stage data memory of a 5-stage MIPS pipeline. Consumes the EX/MEM
// register (instruction, PC, ALU address, rt store data), performs
// sw/sh/sb stores into an internal word array and lw/lh/lhu/lb/lbu loads,
// and registers the results into the MEM/WB boundary.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset (clears memory too)
//   en         in   1   pipeline enable; 0 holds outputs, blocks stores
//   instr_in   in  32   M-stage instruction
//   PC_in      in  32   M-stage PC
//   addr_in    in  32   byte address (ALU result)
//   wdata_in   in  32   store data (rt)
//   instr_out  out 32   W-stage instruction
//   PC_out     out 32   W-stage PC
//   ALU_out    out 32   address passed through to W
//   rdata_out  out 32   extended load data, 0 for non-loads / faults
//   err_out    out  1   misaligned or out-of-range memory access
// Optional: define MEM_STAGE_DM_DISPLAY_EN to print every committed store
// in the course-grader trace format.
module mem_stage_dm
    import mips_pkg::*;
#(
    parameter int DEPTH  = 3072,
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] instr_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] PC_out,
    output logic [31:0] ALU_out,
    output logic [31:0] rdata_out,
    output logic        err_out
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    logic [31:0]       mem_q [DEPTH];

    mem_op_t           op_s;
    logic [ADDR_W-1:0] widx_s;
    logic [1:0]        lane_s;
    logic              in_range_s;
    logic              misalign_s;
    logic              fault_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       ext_s;
    logic [3:0]        be_s;
    logic [31:0]       st_data_s;
    logic [31:0]       merged_s;
    logic              store_en_s;

    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    assign op_s   = decode_op(instr_in[31:26]);
    assign widx_s = addr_in[ADDR_W+1:2];
    assign lane_s = addr_in[1:0];

    // Fault detection; the range check uses the full 32-bit address so
    // aliasing through ignored upper bits is caught.
    always_comb begin
        in_range_s = (addr_in < ADDR_LIMIT);
        misalign_s = 1'b0;
        case (op_s.size)
            SZ_WORD: misalign_s = (lane_s != 2'b00);
            SZ_HALF: misalign_s = lane_s[0];
            SZ_BYTE: misalign_s = 1'b0;
            default: misalign_s = 1'b0;
        endcase
        fault_s = (op_s.is_load | op_s.is_store) & (misalign_s | ~in_range_s);
    end

    // Combinational array read; out-of-range indices never touch the array.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (in_range_s) begin
            rd_word_s = mem_q[widx_s];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    dm_ext u_ext (
        .word_i     (rd_word_s),
        .lane_i     (lane_s),
        .size_i     (op_s.size),
        .sign_ext_i (op_s.sign_ext),
        .data_o     (ext_s)
    );

    // Byte enables and lane-merged store word. Store data is replicated
    // across lanes so a single per-lane mux handles every size.
    always_comb begin
        be_s      = 4'b0000;
        st_data_s = wdata_in;
        if (op_s.is_store && !fault_s) begin
            case (op_s.size)
                SZ_WORD: be_s = 4'b1111;
                SZ_HALF: be_s = lane_s[1] ? 4'b1100 : 4'b0011;
                SZ_BYTE: be_s = 4'b0001 << lane_s;
                default: be_s = 4'b0000;
            endcase
        end else begin
            be_s = 4'b0000;
        end
        case (op_s.size)
            SZ_WORD: st_data_s = wdata_in;
            SZ_HALF: st_data_s = {2{wdata_in[15:0]}};
            SZ_BYTE: st_data_s = {4{wdata_in[7:0]}};
            default: st_data_s = wdata_in;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = be_s[i] ? st_data_s[8*i +: 8] : rd_word_s[8*i +: 8];
        end
        store_en_s = en & (|be_s);
    end

    // Memory array: cleared by reset, written with the merged word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (store_en_s) begin
            mem_q[widx_s] <= merged_s;
        end
    end

    // MEM/WB next-state values.
    always_comb begin
        instr_d = instr_in;
        pc_d    = PC_in;
        alu_d   = addr_in;
        err_d   = fault_s;
        if (op_s.is_load && !fault_s) begin
            rdata_d = ext_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // MEM/WB pipeline register; holds while en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= 32'h0000_0000;
            pc_q    <= PC_RESET;
            alu_q   <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else if (en) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign instr_out = instr_q;
    assign PC_out    = pc_q;
    assign ALU_out   = alu_q;
    assign rdata_out = rdata_q;
    assign err_out   = err_q;

`ifdef MEM_STAGE_DM_DISPLAY_EN
    // Store trace in the grader format.
    always @(posedge clk) begin
        if (reset && store_en_s) begin
            $display("%d@%h: *%h <= %h", $time, PC_in, {addr_in[31:2], 2'b00}, merged_s);
        end
    end
`endif

endmodule
